// File: rtl/busca_instrucao_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pacote_mips
// Description : Constants and FSM encoding shared by the MIPS fetch stage.
// Revision    : 1.0
// ============================================================================
package pacote_mips;

    localparam logic [31:0] NOP          = 32'h0000_0000;
    localparam logic [31:0] INCREMENTO_PC = 32'd4;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        ERRO = 2'b10
    } estado_t;

    function automatic logic alinhado(input logic [31:0] endereco);
        return endereco[1:0] == 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/busca_instrucao_if.sv
`default_nettype none
// ============================================================================
// Module      : busca_instrucao_if
// Description : Hazard/redirect inputs, memory port and IF/ID outputs of fetch.
// Revision    : 1.0
// ============================================================================
interface busca_instrucao_if;

    logic        stall;
    logic        desvio;
    logic [31:0] alvo_desvio;
    logic [31:0] instrucao;
    logic [31:0] pc;
    logic [31:0] if_id_instrucao;
    logic [31:0] if_id_pc4;
    logic        if_id_valido;
    logic        erro_alinhamento;
    logic [31:0] contador_busca;

    modport master (
        input  stall, desvio, alvo_desvio, instrucao,
        output pc, if_id_instrucao, if_id_pc4, if_id_valido,
               erro_alinhamento, contador_busca
    );

    modport slave (
        output stall, desvio, alvo_desvio, instrucao,
        input  pc, if_id_instrucao, if_id_pc4, if_id_valido,
               erro_alinhamento, contador_busca
    );

endinterface
`default_nettype wire

// File: rtl/busca_instrucao_if_id.sv
`default_nettype none
// ============================================================================
// Module      : registrador_if_id
// Description : Pipeline register with enable, synchronous bubble clear and
//               asynchronous active-low reset.
// Revision    : 1.0
// ============================================================================
module registrador_if_id #(
    parameter int WIDTH = 64
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             enable,
    input  wire logic             clear,
    input  wire logic [WIDTH-1:0] dado,
    input  wire logic             valido,
    output logic      [WIDTH-1:0] dado_q,
    output logic                  valido_q
);

    // Clear wins over enable so a squash is never lost behind a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dado_q   <= '0;
            valido_q <= 1'b0;
        end else if (clear) begin
            dado_q   <= '0;
            valido_q <= 1'b0;
        end else if (enable) begin
            dado_q   <= dado;
            valido_q <= valido;
        end
    end

endmodule
`default_nettype wire

// File: rtl/busca_instrucao.sv
`default_nettype none
// ============================================================================
// Module      : busca_instrucao
// Description : MIPS instruction fetch: PC, next-PC mux, boot delay, FSM, IF/ID.
// Revision    : 1.0
// ============================================================================
module busca_instrucao
    import pacote_mips::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 2
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    busca_instrucao_if.master   bus
);

    localparam logic [3:0] BOOT_ULTIMO = 4'(BOOT_CYCLES - 1);
    localparam logic [31:0] PC_INICIAL = {RESET_PC[31:2], 2'b00};

    estado_t     estado;
    estado_t     prox_estado;
    logic [3:0]  cont_boot;
    logic [3:0]  prox_cont_boot;
    logic [31:0] pc_r;
    logic [31:0] prox_pc;
    logic [31:0] pc_mais4;
    logic [31:0] contador_r;
    logic        erro_r;
    logic        limpa_if_id;
    logic        conta;
    logic        seta_erro;
    logic [63:0] if_id_dado;

    assign pc_mais4 = pc_r + INCREMENTO_PC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= BOOT;
            cont_boot  <= 4'd0;
            pc_r       <= PC_INICIAL;
            contador_r <= 32'd0;
            erro_r     <= 1'b0;
        end else begin
            estado     <= prox_estado;
            cont_boot  <= prox_cont_boot;
            pc_r       <= prox_pc;
            if (conta)
                contador_r <= contador_r + 32'd1;
            if (seta_erro)
                erro_r <= 1'b1;
        end
    end

    always_comb begin
        prox_estado    = estado;
        prox_cont_boot = cont_boot;
        prox_pc        = pc_r;
        limpa_if_id    = 1'b1;
        conta          = 1'b0;
        seta_erro      = 1'b0;
        case (estado)
            BOOT: begin
                prox_cont_boot = cont_boot + 4'd1;
                if (cont_boot == BOOT_ULTIMO)
                    prox_estado = RUN;
            end
            RUN: begin
                limpa_if_id = 1'b0;
                // A redirect squashes the current fetch even when stalled.
                if (bus.desvio) begin
                    limpa_if_id = 1'b1;
                    if (!alinhado(bus.alvo_desvio)) begin
                        seta_erro   = 1'b1;
                        prox_estado = ERRO;
                    end else begin
                        prox_pc = bus.alvo_desvio;
                    end
                end else if (!bus.stall) begin
                    prox_pc = pc_mais4;
                    conta   = 1'b1;
                end
            end
            ERRO: begin
                prox_estado = ERRO;
            end
            default: begin
                prox_estado = ERRO;
            end
        endcase
    end

    registrador_if_id #(
        .WIDTH (64)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (~bus.stall),
        .clear    (limpa_if_id),
        .dado     ({bus.instrucao, pc_mais4}),
        .valido   (1'b1),
        .dado_q   (if_id_dado),
        .valido_q (bus.if_id_valido)
    );

    assign bus.pc               = pc_r;
    assign bus.if_id_instrucao  = if_id_dado[63:32];
    assign bus.if_id_pc4        = if_id_dado[31:0];
    assign bus.erro_alinhamento = erro_r;
    assign bus.contador_busca   = contador_r;

endmodule
`default_nettype wire
